// File: rtl/sample_trim.sv
// -----------------------------------------------------------------------------
// sample_trim
//
// Purpose:
//   Receives AXI-Stream packets padded to IN_L samples, throws away the first
//   IN_L-OUT_L samples of each packet and forwards the last OUT_L samples,
//   marking the final forwarded sample with o_tlast. Packets that end early
//   raise err_short; packets that run past IN_L raise err_long and have
//   their excess samples discarded.
//
// Handshake (valid/ready):
//   An input beat is consumed on a rising edge where i_tvalid && i_tready.
//   An output beat is consumed on a rising edge where o_tvalid && o_tready.
//   Once o_tvalid is high, o_tdata/o_tlast stay constant until that beat is
//   consumed. o_tvalid rises exactly one cycle after the input beat that
//   produced it, and the output register reloads on the same edge it is
//   drained, so back-to-back beats have no bubble.
//
// Parameters:
//   WIDTH  sample width in bits
//   OUT_L  samples kept per packet (1..IN_L)
//   IN_L   expected input packet length (1..65535)
//
// Ports:
//   clk            sole clock, rising edge
//   reset_n        asynchronous active-low reset
//   i_tdata/i_tlast/i_tvalid/i_tready   input stream
//   o_tdata/o_tlast/o_tvalid/o_tready   output stream
//   err_short      one-cycle pulse: packet ended before IN_L samples
//   err_long       one-cycle pulse: packet did not end at sample IN_L
//   o_dbg_state    current FSM state (0 DROP, 1 PASS, 2 FLUSH)
//
// Optional feature (macro SAMPLE_TRIM_ERR_CNT_EN):
//   Adds err_short_cnt[15:0] / err_long_cnt[15:0], saturating counts of the
//   respective error pulses. Without the macro these ports do not exist.
// -----------------------------------------------------------------------------
module sample_trim #(
    parameter int WIDTH = 32,
    parameter int OUT_L = 32,
    parameter int IN_L  = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic             err_short,
    output logic             err_long,
`ifdef SAMPLE_TRIM_ERR_CNT_EN
    output logic [15:0]      err_short_cnt,
    output logic [15:0]      err_long_cnt,
`endif
    output logic [1:0]       o_dbg_state
);

    localparam int CW     = $clog2(IN_L + 1);
    localparam int DROP_N = IN_L - OUT_L;

    // Count of the last sample of a well-formed packet, and of the last
    // dropped sample (only meaningful when DROP_N > 0).
    localparam logic [CW-1:0] LAST_CNT  = CW'(IN_L - 1);
    localparam logic [CW-1:0] DROP_LAST = CW'((DROP_N > 0) ? (DROP_N - 1) : 0);

    typedef enum logic [1:0] {
        ST_DROP  = 2'd0,
        ST_PASS  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // When nothing is dropped, every packet starts directly in PASS.
    localparam state_t ST_START = (DROP_N == 0) ? ST_PASS : ST_DROP;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data;
    logic             r_tlast;
    logic             r_valid;
    logic             r_err_short;
    logic             r_err_long;

    logic             w_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_at_last;

    // Only PASS loads the output register, so only PASS needs backpressure.
    assign w_ready    = (r_state == ST_PASS) ? (~r_valid | o_tready) : 1'b1;
    assign w_in_xfer  = i_tvalid & w_ready;
    assign w_out_xfer = r_valid & o_tready;
    assign w_at_last  = (r_count == LAST_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_START;
            r_count     <= '0;
            r_data      <= '0;
            r_tlast     <= 1'b0;
            r_valid     <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;

            // Drain first; a PASS load on the same edge overrides this.
            if (w_out_xfer) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                ST_DROP: begin
                    if (w_in_xfer) begin
                        // DROP never reaches LAST_CNT, so any tlast here is early.
                        if (i_tlast) begin
                            r_err_short <= 1'b1;
                            r_count     <= '0;
                            r_state     <= ST_START;
                        end else begin
                            r_count <= r_count + CW'(1);
                            if (r_count == DROP_LAST) begin
                                r_state <= ST_PASS;
                            end
                        end
                    end
                end

                ST_PASS: begin
                    if (w_in_xfer) begin
                        r_data  <= i_tdata;
                        r_valid <= 1'b1;
                        r_tlast <= i_tlast | w_at_last;
                        if (w_at_last) begin
                            r_count <= '0;
                            if (i_tlast) begin
                                r_state <= ST_START;
                            end else begin
                                r_err_long <= 1'b1;
                                r_state    <= ST_FLUSH;
                            end
                        end else if (i_tlast) begin
                            r_err_short <= 1'b1;
                            r_count     <= '0;
                            r_state     <= ST_START;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end

                ST_FLUSH: begin
                    // Excess samples of an over-long packet are swallowed.
                    if (w_in_xfer && i_tlast) begin
                        r_count <= '0;
                        r_state <= ST_START;
                    end
                end

                default: begin
                    r_count <= '0;
                    r_state <= ST_START;
                end
            endcase
        end
    end

    assign i_tready    = w_ready;
    assign o_tdata     = r_data;
    assign o_tlast     = r_tlast;
    assign o_tvalid    = r_valid;
    assign err_short   = r_err_short;
    assign err_long    = r_err_long;
    assign o_dbg_state = r_state;

`ifdef SAMPLE_TRIM_ERR_CNT_EN
    logic [15:0] r_short_cnt;
    logic [15:0] r_long_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_short_cnt <= '0;
            r_long_cnt  <= '0;
        end else begin
            if (r_err_short && (r_short_cnt != 16'hFFFF)) begin
                r_short_cnt <= r_short_cnt + 16'd1;
            end
            if (r_err_long && (r_long_cnt != 16'hFFFF)) begin
                r_long_cnt <= r_long_cnt + 16'd1;
            end
        end
    end

    assign err_short_cnt = r_short_cnt;
    assign err_long_cnt  = r_long_cnt;
`endif

endmodule

// File: tb/tb_sample_trim.sv
module tb_sample_trim;

    localparam int WIDTH  = 32;
    localparam int OUT_L  = 4;
    localparam int IN_L   = 8;
    localparam int DROP_N = IN_L - OUT_L;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] i_tdata;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;
    logic             err_short;
    logic             err_long;
    logic [1:0]       o_dbg_state;
`ifdef SAMPLE_TRIM_ERR_CNT_EN
    logic [15:0]      err_short_cnt;
    logic [15:0]      err_long_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] got_q[$];
    int             n_short = 0;
    int             n_long  = 0;
    logic           mon_prev_stall = 1'b0;
    logic [WIDTH-1:0] mon_prev_data = '0;
    logic           m_valid;

    sample_trim #(
        .WIDTH (WIDTH),
        .OUT_L (OUT_L),
        .IN_L  (IN_L)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_tdata       (i_tdata),
        .i_tlast       (i_tlast),
        .i_tvalid      (i_tvalid),
        .i_tready      (i_tready),
        .o_tdata       (o_tdata),
        .o_tlast       (o_tlast),
        .o_tvalid      (o_tvalid),
        .o_tready      (o_tready),
        .err_short     (err_short),
        .err_long      (err_long),
`ifdef SAMPLE_TRIM_ERR_CNT_EN
        .err_short_cnt (err_short_cnt),
        .err_long_cnt  (err_long_cnt),
`endif
        .o_dbg_state   (o_dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // monitor: collect output beats, count error pulses, check stall hold
    always @(negedge clk) begin
        if (o_tvalid && o_tready) got_q.push_back({o_tlast, o_tdata});
        if (err_short) n_short <= n_short + 1;
        if (err_long)  n_long  <= n_long + 1;
        if (mon_prev_stall && reset_n) begin
            chk("stall_hold_data", 64'(o_tdata), 64'(mon_prev_data));
            chk("stall_hold_valid", 64'(o_tvalid), 64'd1);
        end
        mon_prev_stall <= reset_n && o_tvalid && !o_tready;
        mon_prev_data  <= o_tdata;
    end

    task automatic idle(input int n);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_tdata  = '0;
        o_tready = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends samples 0..n-1; tlast on the final one when use_last is set.
    // With toggle set, o_tready flips every cycle and i_tready/o_tvalid are
    // checked against a small model of the output register.
    task automatic send_pkt(input int n, input bit toggle, input bit use_last);
        int  k;
        int  budget;
        bit  xfer;
        k = 0;
        budget = 0;
        m_valid = 1'b0;
        while (k < n) begin
            i_tdata  = WIDTH'(k);
            i_tlast  = use_last && (k == n - 1);
            i_tvalid = 1'b1;
            if (toggle) o_tready = ~o_tready;
            else        o_tready = 1'b1;
            @(negedge clk);
            if (toggle) begin
                chk("pass_o_tvalid", 64'(o_tvalid), 64'(m_valid));
                chk("pass_i_tready", 64'(i_tready),
                    64'(!(k >= DROP_N && k < IN_L && m_valid && !o_tready)));
            end
            xfer = i_tready;
            if (m_valid && o_tready) m_valid = 1'b0;
            if (xfer && k >= DROP_N && k < IN_L) m_valid = 1'b1;
            if (xfer) k++;
            @(posedge clk);
            #1;
            budget++;
            if (budget > 200) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic expect_seq(input string tag, input int first, input int cnt);
        exp_q.delete();
        for (int i = 0; i < cnt; i++) exp_q.push_back({(i == cnt - 1), WIDTH'(first + i)});
        chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < cnt && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
    endtask

    initial begin
        int s0;
        int l0;
        reset_n  = 1'b0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
        chk("rst_o_tdata", 64'(o_tdata), 64'd0);
        chk("rst_o_tlast", 64'(o_tlast), 64'd0);
        chk("rst_err_short", 64'(err_short), 64'd0);
        chk("rst_err_long", 64'(err_long), 64'd0);
        chk("rst_state", 64'(o_dbg_state), 64'd0);
        chk("rst_i_tready", 64'(i_tready), 64'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // nominal packet, cycle-by-cycle latency and back-to-back output
        s0 = n_short; l0 = n_long;
        o_tready = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            if (k < 8) begin
                i_tdata = WIDTH'(k); i_tlast = (k == 7); i_tvalid = 1'b1;
            end else begin
                i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("s1_valid_c%0d", k), 64'(o_tvalid), 64'(k - 1 >= 4 && k - 1 <= 7));
            if (k - 1 >= 4 && k - 1 <= 7) begin
                chk($sformatf("s1_data_c%0d", k), 64'(o_tdata), 64'(k - 1));
                chk($sformatf("s1_last_c%0d", k), 64'(o_tlast), 64'(k - 1 == 7));
            end
            if (k < 8) chk($sformatf("s1_rdy_c%0d", k), 64'(i_tready), 64'd1);
            @(posedge clk);
            #1;
        end
        idle(2);
        expect_seq("s1", 4, 4);
        chk("s1_err_short", 64'(n_short - s0), 64'd0);
        chk("s1_err_long", 64'(n_long - l0), 64'd0);

        // output backpressure toggling
        s0 = n_short; l0 = n_long;
        o_tready = 1'b0;
        send_pkt(8, 1'b1, 1'b1);
        idle(4);
        expect_seq("s2", 4, 4);
        chk("s2_err_short", 64'(n_short - s0), 64'd0);

        // short packet then normal packet
        s0 = n_short; l0 = n_long;
        send_pkt(6, 1'b0, 1'b1);
        idle(3);
        expect_seq("s3_short", 4, 2);
        chk("s3_err_short", 64'(n_short - s0), 64'd1);
        chk("s3_err_long", 64'(n_long - l0), 64'd0);
        chk("s3_state", 64'(o_dbg_state), 64'd0);
        send_pkt(8, 1'b0, 1'b1);
        idle(3);
        expect_seq("s3_next", 4, 4);

        // long packet then normal packet
        s0 = n_short; l0 = n_long;
        send_pkt(11, 1'b0, 1'b1);
        idle(3);
        expect_seq("s4_long", 4, 4);
        chk("s4_err_long", 64'(n_long - l0), 64'd1);
        chk("s4_err_short", 64'(n_short - s0), 64'd0);
        chk("s4_state", 64'(o_dbg_state), 64'd0);
        send_pkt(8, 1'b0, 1'b1);
        idle(3);
        expect_seq("s4_next", 4, 4);

        // reset mid-packet, after sample 5 was accepted
        send_pkt(6, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("s5_rst_valid", 64'(o_tvalid), 64'd0);
        chk("s5_rst_data", 64'(o_tdata), 64'd0);
        chk("s5_rst_last", 64'(o_tlast), 64'd0);
        chk("s5_rst_state", 64'(o_dbg_state), 64'd0);
        chk("s5_pre_len", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) chk("s5_pre_beat", 64'(got_q[0]), 64'd4);
        got_q.delete();
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(8, 1'b0, 1'b1);
        idle(3);
        expect_seq("s5_next", 4, 4);

`ifdef SAMPLE_TRIM_ERR_CNT_EN
        // error counters (cleared by the reset above)
        repeat (3) begin
            send_pkt(6, 1'b0, 1'b1);
            idle(2);
        end
        repeat (2) begin
            send_pkt(11, 1'b0, 1'b1);
            idle(2);
        end
        idle(2);
        got_q.delete();
        chk("s6_short_cnt", 64'(err_short_cnt), 64'd3);
        chk("s6_long_cnt", 64'(err_long_cnt), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sample_trim.md
SAMPLE_TRIM -- requirements
Module: sample_trim

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, sample width in bits.
REQ-002 The block SHALL have parameter OUT_L, default 32, samples kept per packet; legal range 1..IN_L.
REQ-003 The block SHALL have parameter IN_L, default 64, expected input packet length; legal range 1..65535.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports i_tdata / i_tlast / i_tvalid, input, WIDTH/1/1, AXI-Stream input of padded-length packets.
REQ-007 The block SHALL have port i_tready, output, 1, input backpressure.
REQ-008 The block SHALL have ports o_tdata / o_tlast / o_tvalid, output, WIDTH/1/1, AXI-Stream output of trimmed packets.
REQ-009 The block SHALL have port o_tready, input, 1, output backpressure.
REQ-010 The block SHALL have ports err_short / err_long, output, 1 each, single-cycle error pulses.

Function
REQ-011 The block SHALL discard the first IN_L-OUT_L samples of each input packet and forward the last OUT_L, with o_tlast on the final forwarded sample.
REQ-012 An input transfer SHALL occur only when i_tvalid and i_tready are both 1; an output transfer only when o_tvalid and o_tready are both 1.
REQ-013 The block SHALL have a single registered output stage; latency from input transfer to o_tvalid SHALL be exactly 1 cycle.
REQ-014 The block SHALL implement states DROP, PASS, FLUSH; after reset the state SHALL be DROP with sample counter 0.
REQ-015 In DROP, i_tready SHALL be 1; each transfer SHALL increment the counter; on the transfer with count IN_L-OUT_L-1 the state SHALL move to PASS; when IN_L equals OUT_L, DROP SHALL be skipped.
REQ-016 In PASS, i_tready SHALL be (~o_tvalid | o_tready); each transfer SHALL load the output register and increment the counter.
REQ-017 On the PASS transfer with count IN_L-1 and i_tlast=1, o_tlast SHALL be set, the counter SHALL clear, and the state SHALL return to DROP.
REQ-018 On the PASS transfer with count IN_L-1 and i_tlast=0, o_tlast SHALL be set, err_long SHALL pulse, and the state SHALL move to FLUSH.
REQ-019 In FLUSH, i_tready SHALL be 1 and samples SHALL be discarded; the transfer carrying i_tlast SHALL return the state to DROP with counter 0.
REQ-020 If i_tlast transfers before count IN_L-1 in DROP, err_short SHALL pulse, nothing SHALL be output, and the state SHALL stay in DROP with counter 0.
REQ-021 If i_tlast transfers before count IN_L-1 in PASS, that sample SHALL be output with o_tlast=1, err_short SHALL pulse, and the state SHALL return to DROP with counter 0.
REQ-022 The counter SHALL be $clog2(IN_L+1) bits wide and SHALL never wrap; it SHALL clear at every packet boundary.
REQ-023 The output register SHALL hold data stable while o_tvalid=1 and o_tready=0.
REQ-024 If o_tready=1 and a new PASS input arrives in the same cycle, the output register SHALL reload without a bubble.

Reset
REQ-025 Assertion of reset_n=0 SHALL immediately force o_tvalid=0, o_tlast=0, o_tdata=0, err_short=0, err_long=0, state DROP, and counter 0, including mid-packet.
REQ-026 The first packet after reset release SHALL be treated as a fresh packet starting at count 0.

Configuration
REQ-027 With SAMPLE_TRIM_ERR_CNT_EN defined, the block SHALL add output ports err_short_cnt[15:0] and err_long_cnt[15:0], reset to 0, incremented on each respective pulse, and saturating at 16'hFFFF.
REQ-028 Without SAMPLE_TRIM_ERR_CNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification (OUT_L=4, IN_L=8)
REQ-029 Scenario: packet 0..7 with tlast on 7 and o_tready=1 -> output 4,5,6,7, o_tlast on 7, each one cycle after its input, no error pulses.
REQ-030 Scenario: same packet with o_tready toggled 1/0 each cycle -> output still exactly 4,5,6,7, data stable while stalled, i_tready=0 only in PASS while stalled.
REQ-031 Scenario: packet 0..5 with tlast on 5 -> output 4,5 with o_tlast on 5 and one err_short pulse; a following packet 0..7 -> 4..7.
REQ-032 Scenario: packet 0..10 with tlast on 10 -> output 4..7 with o_tlast on 7, err_long pulse, 8..10 discarded, next packet normal.
REQ-033 Scenario: reset_n pulsed low after input sample 5 -> o_tvalid=0 at once; the next full packet 0..7 -> 4..7.
REQ-034 Scenario: with SAMPLE_TRIM_ERR_CNT_EN, 3 short packets then 2 long -> err_short_cnt=3, err_long_cnt=2.
